bus_rr_router_mb: RTL and testbench
===================================

// Module: bus_rr_router_mb
//
// PURPOSE
//   Next-generation bus generator/arbiter: BITS independent buses, each
//   shared by DRVRS drivers. Per bus, a round-robin arbiter pops one packet
//   from a pending driver FIFO and decodes its destination ID. It then
//   pushes the packet to that one driver (unicast) or to all others
//   (broadcast), honouring per-destination full backpressure.
//   Sits between the driver-side FIFOs and the bus fabric.
//
// PARAMETERS
//   PCKG_SZ   16    packet width; [PCKG_SZ-1 -: 8] = destination ID, rest payload
//   DRVRS     4     drivers per bus (2..254)
//   BITS      1     number of independent buses (one arbiter FSM each)
//   BROADCAST 8'hFF destination ID meaning "all drivers except source"
//
// PORTS
//   clk     in   1                    bus clock
//   reset   in   1                    asynchronous, active-low reset
//   pndng   in   [BITS][DRVRS]        driver FIFO non-empty (FWFT)
//   D_pop   in   [BITS][DRVRS][PCKG_SZ] head-of-FIFO data, valid while pndng=1
//   pop     out  [BITS][DRVRS]        one-cycle pop strobe to driver FIFO
//   full    in   [BITS][DRVRS]        destination FIFO cannot accept
//   push    out  [BITS][DRVRS]        one-cycle push strobe to destination(s)
//   D_push  out  [BITS][PCKG_SZ]      packet on bus b (shared by its drivers)
//   err     out  [BITS]               one-cycle pulse: packet dropped, bad ID
//
// BEHAVIOUR
//   - Reset (reset=0, async): pop=0, push=0, D_push=0, err=0, FSM=IDLE,
//     rr pointer=0. Mid-packet reset discards the captured packet.
//   - Buses fully independent; all rules below apply per bus b.
//   - FSM IDLE: if any pndng -> grant = first pending index at or after rr
//     pointer (wraps DRVRS-1 -> 0); register grant; -> POP. Otherwise stay.
//   - POP: pop[grant]=1 for exactly this cycle if pndng[grant]=1. D_pop is
//     captured into the packet register in the same cycle. Decode ID:
//     ID<DRVRS -> unicast target mask; ID==BROADCAST -> all except grant;
//     else -> err=1 next cycle, packet dropped, rr=grant+1, -> IDLE.
//     If pndng[grant]=0 here: no pop, no err, -> IDLE, rr unchanged.
//   - PUSH: D_push = packet register, held stable for the whole state.
//     push[d]=target[d] in the single cycle where full[d]=0 for every target
//     (all-or-nothing). Then rr=grant+1 (mod DRVRS) and -> IDLE. Otherwise
//     wait indefinitely with push=0.
//   - Unicast to self (ID==grant) is delivered. Broadcast never to source.
//   - pop/push combinational from state, grant, target and full. D_push, err
//     registered. Min latency pndng rise -> push = 2 cycles; 3 cycles/packet.
//   - pop and push never both asserted on the same bus in one cycle.
//
// CONFIGURATION
//   BUS_STATS_EN defined: adds outputs pkt_cnt[BITS][32] (+1 per PUSH
//     completion) and drop_cnt[BITS][16] (+1 per err pulse). Both
//     saturating, reset to 0.
//   BUS_STATS_EN undefined: ports and counters absent; behaviour otherwise identical.
//
// TESTING
//   1 After reset release, pndng[0][2]=1, D_pop=16'h01AB, full=0 -> pop[0][2]
//     in cycle 2, push[0][1] in cycle 3 with D_push=16'h01AB, all else 0.
//   2 All 4 drivers pending, all ID 0 -> grant order 0,1,2,3,0; each pop
//     exactly 3 cycles apart; no driver served twice before others.
//   3 Driver 1 sends 16'hFF55 -> push[0]=4'b1101 in one cycle, D_push=16'hFF55.
//   4 Unicast to driver 3 with full[0][3]=1 for 10 cycles -> push held 0,
//     D_push stable; push[0][3]=1 the first cycle full drops.
//   5 Driver 0 sends ID 8'h07 (DRVRS=4) -> pop, err[0] pulse, no push;
//     with BUS_STATS_EN drop_cnt[0]=1, pkt_cnt[0]=0.
//   6 Assert reset during PUSH wait -> push=0, D_push=0 immediately; packet
//     lost; after release driver 0 granted first.

Source files
------------

// File: rtl/bus_rr_router_mb.sv
// -----------------------------------------------------------------------------
// bus_rr_router_mb
//
// Purpose:
//   BITS independent buses, each shared by DRVRS drivers. On every bus a
//   round-robin arbiter takes one packet from a pending driver FIFO and decodes
//   its destination ID from the top byte. The packet then goes to one driver
//   (unicast) or to every driver except the source (broadcast). A destination
//   that reports full holds the transfer back. A packet with an unknown ID is
//   dropped and flagged on err.
//
// Ports:
//   clk          bus clock
//   reset        asynchronous, active-low reset
//   pndng        [BITS][DRVRS]          driver FIFO non-empty (first-word fall-through)
//   D_pop        [BITS][DRVRS][PCKG_SZ] head-of-FIFO data, valid while pndng=1
//   pop          [BITS][DRVRS]          one-cycle pop strobe to the granted driver FIFO
//   full         [BITS][DRVRS]          destination FIFO cannot accept
//   push         [BITS][DRVRS]          one-cycle push strobe to the destination(s)
//   D_push       [BITS][PCKG_SZ]        packet driven on each bus
//   err          [BITS]                 one-cycle pulse when a packet is dropped (bad ID)
//   o_dbg_state  [BITS][2]              arbiter FSM state per bus (0 idle, 1 pop, 2 push)
//   pkt_cnt      [BITS][32]             saturating count of delivered packets (BUS_STATS_EN only)
//   drop_cnt     [BITS][16]             saturating count of dropped packets (BUS_STATS_EN only)
//
// Configuration:
//   BUS_STATS_EN  when defined, adds the pkt_cnt / drop_cnt outputs.
//
// Handshake:
//   Driver side: a FIFO offers its head word while pndng=1. A one-cycle pop
//   consumes that word, and D_pop is sampled in the same cycle. Bus side: push
//   is raised only in a cycle where no targeted destination reports full. Push
//   is therefore a completed transfer, and it is never retried.
// -----------------------------------------------------------------------------
module bus_rr_router_mb #(
  parameter int         PCKG_SZ   = 16,
  parameter int         DRVRS     = 4,
  parameter int         BITS      = 1,
  parameter logic [7:0] BROADCAST = 8'hFF
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [BITS-1:0][DRVRS-1:0]             pndng,
  input  logic [BITS-1:0][DRVRS-1:0][PCKG_SZ-1:0] D_pop,
  output logic [BITS-1:0][DRVRS-1:0]             pop,
  input  logic [BITS-1:0][DRVRS-1:0]             full,
  output logic [BITS-1:0][DRVRS-1:0]             push,
  output logic [BITS-1:0][PCKG_SZ-1:0]           D_push,
  output logic [BITS-1:0]                        err,
  output logic [BITS-1:0][1:0]                   o_dbg_state
`ifdef BUS_STATS_EN
  ,
  output logic [BITS-1:0][31:0]                  pkt_cnt,
  output logic [BITS-1:0][15:0]                  drop_cnt
`endif
);

  localparam int IW = (DRVRS > 1) ? $clog2(DRVRS) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_POP  = 2'd1,
    S_PUSH = 2'd2
  } state_t;

  for (genvar b = 0; b < BITS; b++) begin : g_bus
    state_t             r_state;
    logic [IW-1:0]      r_rr;
    logic [IW-1:0]      r_grant;
    logic [DRVRS-1:0]   r_target;
    logic [PCKG_SZ-1:0] r_pkt;
    logic               r_err;

    logic [IW-1:0]      w_hi;
    logic [IW-1:0]      w_lo;
    logic               w_hi_found;
    logic               w_any;
    logic [IW-1:0]      w_next_grant;
    logic [IW-1:0]      w_grant_inc;
    logic [PCKG_SZ-1:0] w_head;
    logic [7:0]         w_id;
    logic               w_id_uni;
    logic               w_id_bc;
    logic [DRVRS-1:0]   w_uni;
    logic [DRVRS-1:0]   w_bc;
    logic [DRVRS-1:0]   w_gnt_oh;
    logic               w_blocked;

    // Round-robin search. The loop runs downward, so the last hit is the
    // lowest index. w_hi is the lowest pending index at or above the pointer.
    // w_lo is the lowest pending index overall, which covers the wrap case.
    always_comb begin
      w_hi       = '0;
      w_lo       = '0;
      w_hi_found = 1'b0;
      for (int i = DRVRS - 1; i >= 0; i--) begin
        if (pndng[b][i]) begin
          w_lo = IW'(i);
          if (IW'(i) >= r_rr) begin
            w_hi       = IW'(i);
            w_hi_found = 1'b1;
          end
        end
      end
    end

    assign w_any        = |pndng[b];
    assign w_next_grant = w_hi_found ? w_hi : w_lo;
    assign w_grant_inc  = (r_grant == IW'(DRVRS - 1)) ? '0 : r_grant + 1'b1;

    assign w_head   = D_pop[b][r_grant];
    assign w_id     = w_head[PCKG_SZ-1 -: 8];
    assign w_id_uni = (32'(w_id) < DRVRS);
    assign w_id_bc  = (w_id == BROADCAST);

    always_comb begin
      w_uni    = '0;
      w_bc     = '0;
      w_gnt_oh = '0;
      for (int d = 0; d < DRVRS; d++) begin
        w_uni[d]    = (32'(w_id) == d);
        w_bc[d]     = (r_grant != IW'(d));
        w_gnt_oh[d] = (r_grant == IW'(d));
      end
    end

    // A transfer goes out only when every targeted destination can accept.
    assign w_blocked = |(r_target & full[b]);

    assign pop[b]         = (r_state == S_POP) ? (w_gnt_oh & pndng[b]) : '0;
    assign push[b]        = (r_state == S_PUSH && !w_blocked) ? r_target : '0;
    assign D_push[b]      = r_pkt;
    assign err[b]         = r_err;
    assign o_dbg_state[b] = r_state;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_state  <= S_IDLE;
        r_rr     <= '0;
        r_grant  <= '0;
        r_target <= '0;
        r_pkt    <= '0;
        r_err    <= 1'b0;
      end else begin
        r_err <= 1'b0;
        case (r_state)
          S_IDLE: begin
            if (w_any) begin
              r_grant <= w_next_grant;
              r_state <= S_POP;
            end
          end
          S_POP: begin
            if (pndng[b][r_grant]) begin
              r_pkt <= w_head;
              if (w_id_uni) begin
                r_target <= w_uni;
                r_state  <= S_PUSH;
              end else if (w_id_bc) begin
                r_target <= w_bc;
                r_state  <= S_PUSH;
              end else begin
                // Unknown ID: the word is consumed but not forwarded.
                r_err   <= 1'b1;
                r_rr    <= w_grant_inc;
                r_state <= S_IDLE;
              end
            end else begin
              // The head disappeared before the pop. Keep the pointer so this
              // driver keeps its turn.
              r_state <= S_IDLE;
            end
          end
          S_PUSH: begin
            if (!w_blocked) begin
              r_rr    <= w_grant_inc;
              r_state <= S_IDLE;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end

`ifdef BUS_STATS_EN
    logic [31:0] r_pkt_cnt;
    logic [15:0] r_drop_cnt;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_pkt_cnt  <= '0;
        r_drop_cnt <= '0;
      end else begin
        if (r_state == S_PUSH && !w_blocked && r_pkt_cnt != '1) begin
          r_pkt_cnt <= r_pkt_cnt + 32'd1;
        end
        if (r_err && r_drop_cnt != '1) begin
          r_drop_cnt <= r_drop_cnt + 16'd1;
        end
      end
    end

    assign pkt_cnt[b]  = r_pkt_cnt;
    assign drop_cnt[b] = r_drop_cnt;
`endif
  end

endmodule

// File: tb/tb_bus_rr_router_mb.sv
// -----------------------------------------------------------------------------
// tb_bus_rr_router_mb
//
// Bench for bus_rr_router_mb with one bus and four drivers. A driver-FIFO model
// feeds pndng/D_pop from per-driver queues. Each directed vector pushes its
// hand-computed pop strobe and bus output into expected queues. Monitors pop
// those queues and compare whenever the DUT pops, pushes or signals err.
// -----------------------------------------------------------------------------
module tb_bus_rr_router_mb;
  localparam int PCKG_SZ = 16;
  localparam int DRVRS   = 4;
  localparam int BITS    = 1;

  logic                                    clk = 1'b0;
  logic                                    rst_n = 1'b0;
  logic [BITS-1:0][DRVRS-1:0]              pndng;
  logic [BITS-1:0][DRVRS-1:0][PCKG_SZ-1:0] d_pop;
  logic [BITS-1:0][DRVRS-1:0]              pop;
  logic [BITS-1:0][DRVRS-1:0]              full;
  logic [BITS-1:0][DRVRS-1:0]              push;
  logic [BITS-1:0][PCKG_SZ-1:0]            d_push;
  logic [BITS-1:0]                         err;
  logic [BITS-1:0][1:0]                    dbg_state;
`ifdef BUS_STATS_EN
  logic [BITS-1:0][31:0]                   pkt_cnt;
  logic [BITS-1:0][15:0]                   drop_cnt;
`endif

  bus_rr_router_mb #(
    .PCKG_SZ  (PCKG_SZ),
    .DRVRS    (DRVRS),
    .BITS     (BITS),
    .BROADCAST(8'hFF)
  ) dut (
    .clk        (clk),
    .reset      (rst_n),
    .pndng      (pndng),
    .D_pop      (d_pop),
    .pop        (pop),
    .full       (full),
    .push       (push),
    .D_push     (d_push),
    .err        (err),
    .o_dbg_state(dbg_state)
`ifdef BUS_STATS_EN
    ,
    .pkt_cnt    (pkt_cnt),
    .drop_cnt   (drop_cnt)
`endif
  );

  // ---------------- clock / reset / cycle counter ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [15:0] drv_q [DRVRS][$];
  logic [20:0] exp_q[$];          // {err, push mask, D_push}
  logic [3:0]  exp_pop_q[$];
  int          n_chk = 0;
  int          n_fail = 0;
  int          last_pop_cyc = 0;
  int          last_out_cyc = 0;
  int          prev_pop_cyc = -1;
  bit          gap_chk = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- driver FIFO model ----------------
  initial begin
    logic [3:0] s_pop;
    pndng = '0;
    d_pop = '0;
    forever begin
      @(negedge clk);
      s_pop = pop[0];
      @(posedge clk);
      #1;
      for (int d = 0; d < DRVRS; d++) begin
        if (s_pop[d] && drv_q[d].size() > 0) void'(drv_q[d].pop_front());
        pndng[0][d] = (drv_q[d].size() > 0);
        d_pop[0][d] = (drv_q[d].size() > 0) ? drv_q[d][0] : 16'h0000;
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin
    logic [3:0]  e_pop;
    logic [20:0] e_out;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (pop[0] != 4'b0 && push[0] != 4'b0) begin
          n_chk++;
          n_fail++;
          $display("FAIL pop_push_overlap: pop=%b push=%b, required one of them 0", pop[0], push[0]);
        end
        if (pop[0] != 4'b0) begin
          if (exp_pop_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL pop_unexpected: pop=%b, required no pop", pop[0]);
          end else begin
            e_pop = exp_pop_q.pop_front();
            chk("pop_vector", 32'(pop[0]), 32'(e_pop));
          end
          if (gap_chk) begin
            if (prev_pop_cyc >= 0) chk("pop_spacing", 32'(cyc - prev_pop_cyc), 32'd3);
            prev_pop_cyc = cyc;
          end
          last_pop_cyc = cyc;
        end
        if (push[0] != 4'b0 || err[0]) begin
          if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL out_unexpected: push=%b err=%b d_push=%h, required no output",
                     push[0], err[0], d_push[0]);
          end else begin
            e_out = exp_q.pop_front();
            if (e_out[20]) chk("err_out", {27'd0, err[0], push[0]}, {27'd0, 1'b1, 4'b0000});
            else           chk("push_out", {11'd0, err[0], push[0], d_push[0]}, {11'd0, e_out});
          end
          last_out_cyc = cyc;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Queue a word at driver d and record what the DUT must do with it.
  task automatic send(input int d, input logic [15:0] data, input logic [3:0] e_pop,
                      input logic [3:0] e_mask, input bit e_err, input bit e_out);
    drv_q[d].push_back(data);
    exp_pop_q.push_back(e_pop);
    if (e_out) exp_q.push_back({e_err, e_mask, data});
  endtask

  task automatic wait_drain(input string name);
    int pend;
    pend = 1;
    for (int i = 0; i < 300 && pend != 0; i++) begin
      @(negedge clk);
      pend = exp_q.size() + exp_pop_q.size();
      for (int d = 0; d < DRVRS; d++) pend += drv_q[d].size();
    end
    chk(name, 32'(pend), 32'd0);
  endtask

  task automatic wait_state(input logic [1:0] st, input string name);
    for (int i = 0; i < 50 && dbg_state[0] !== st; i++) @(negedge clk);
    chk(name, 32'(dbg_state[0]), 32'(st));
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    full  = '0;
    repeat (2) @(posedge clk);
    for (int d = 0; d < DRVRS; d++) drv_q[d].delete();
    exp_q.delete();
    exp_pop_q.delete();
    #1;
    rst_n = 1'b1;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, n_fail=%0d", n_fail);
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int issue;
    int rel;
    full = '0;
    repeat (2) @(negedge clk);
    chk("rst_pop",    32'(pop[0]),       32'd0);
    chk("rst_push",   32'(push[0]),      32'd0);
    chk("rst_d_push", 32'(d_push[0]),    32'd0);
    chk("rst_err",    32'(err[0]),       32'd0);
    chk("rst_state",  32'(dbg_state[0]), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // 1: single unicast from driver 2 to driver 1, minimum latency
    @(negedge clk);
    issue = cyc;
    send(2, 16'h01AB, 4'b0100, 4'b0010, 1'b0, 1'b1);
    wait_drain("t1_drain");
    chk("t1_pop_cycle",  32'(last_pop_cyc - issue), 32'd2);
    chk("t1_push_cycle", 32'(last_out_cyc - issue), 32'd3);

    // 2: all four pending, ID 0, driver 0 holds a second word
    do_reset();
    gap_chk      = 1'b1;
    prev_pop_cyc = -1;
    @(negedge clk);
    send(0, 16'h00A0, 4'b0001, 4'b0001, 1'b0, 1'b1);
    send(1, 16'h00A1, 4'b0010, 4'b0001, 1'b0, 1'b1);
    send(2, 16'h00A2, 4'b0100, 4'b0001, 1'b0, 1'b1);
    send(3, 16'h00A3, 4'b1000, 4'b0001, 1'b0, 1'b1);
    send(0, 16'h00B0, 4'b0001, 4'b0001, 1'b0, 1'b1);
    wait_drain("t2_drain");
    gap_chk = 1'b0;

    // 3: broadcast from driver 1 skips the source
    @(negedge clk);
    send(1, 16'hFF55, 4'b0010, 4'b1101, 1'b0, 1'b1);
    wait_drain("t3_drain");

    // 4: unicast to a full driver 3, held for 10 cycles
    @(posedge clk);
    #1;
    full[0][3] = 1'b1;
    @(negedge clk);
    send(2, 16'h03C4, 4'b0100, 4'b1000, 1'b0, 1'b1);
    wait_state(2'd2, "t4_reach_push");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t4_hold", {12'd0, push[0], d_push[0]}, {12'd0, 4'b0000, 16'h03C4});
    end
    @(posedge clk);
    #1;
    full[0][3] = 1'b0;
    rel = cyc;
    wait_drain("t4_drain");
    chk("t4_release_cycle", 32'(last_out_cyc), 32'(rel));

    // 5: bad destination ID is dropped with an err pulse
    do_reset();
    @(negedge clk);
    issue = cyc;
    send(0, 16'h0742, 4'b0001, 4'b0000, 1'b1, 1'b1);
    wait_drain("t5_drain");
    chk("t5_err_cycle", 32'(last_out_cyc - issue), 32'd3);
    repeat (2) @(negedge clk);
`ifdef BUS_STATS_EN
    chk("t5_drop_cnt", 32'(drop_cnt[0]), 32'd1);
    chk("t5_pkt_cnt",  pkt_cnt[0],       32'd0);
`endif

    // 6: reset during a blocked push loses the packet and clears the pointer
    @(posedge clk);
    #1;
    full[0][1] = 1'b1;
    @(negedge clk);
    send(2, 16'h0155, 4'b0100, 4'b0010, 1'b0, 1'b0);
    wait_state(2'd2, "t6_reach_push");
    repeat (3) @(negedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_push",   32'(push[0]),      32'd0);
    chk("t6_rst_d_push", 32'(d_push[0]),    32'd0);
    chk("t6_rst_state",  32'(dbg_state[0]), 32'd0);
    repeat (2) @(posedge clk);
    for (int d = 0; d < DRVRS; d++) drv_q[d].delete();
    exp_q.delete();
    exp_pop_q.delete();
    full = '0;
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    send(0, 16'h02AA, 4'b0001, 4'b0100, 1'b0, 1'b1);
    send(3, 16'h0011, 4'b1000, 4'b0001, 1'b0, 1'b1);
    wait_drain("t6_drain");

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
